// File: rtl/one_hot_encoder_pkg.sv
// Shared widths, the chunk record type and a width helper for the one-hot encoder pipe.
// The chunk record is sized from the default chunk width; instances must keep CHUNK_SIZE at CHUNK_SIZE_DEF.
package one_hot_encoder_pkg;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int INPUT_SIZE_DEF = 8;
  localparam int CHUNK_SIZE_DEF = 4;
  localparam int NUM_CHUNKS     = INPUT_SIZE_DEF / CHUNK_SIZE_DEF;
  localparam int CHUNK_BW       = clog2_f(CHUNK_SIZE_DEF);

  typedef struct packed {
    logic                any;
    logic                multi;
    logic [CHUNK_BW-1:0] idx;
  } chunk_rec_t;

endpackage

// File: rtl/one_hot_chunk_encoder.sv
// Combinational partial encoder for one chunk: any-set, more-than-one-set, lowest set index.
module one_hot_chunk_encoder
  import one_hot_encoder_pkg::*;
#(
  parameter int CHUNK_SIZE = CHUNK_SIZE_DEF
) (
  input  logic [CHUNK_SIZE-1:0] bits,
  output chunk_rec_t            rec
);

  // Scan from the top so the lowest set bit is the last to write idx.
  always_comb begin
    rec = '0;
    for (int i = CHUNK_SIZE - 1; i >= 0; i--) begin
      if (bits[i]) begin
        if (rec.any) rec.multi = 1'b1;
        rec.any = 1'b1;
        rec.idx = CHUNK_BW'(i);
      end
    end
  end

endmodule

// File: rtl/one_hot_encoder_pipe.sv
// Two-stage one-hot to binary encoder with valid/ready on both sides,
// malformed-input flags and a saturating error counter.
module one_hot_encoder_pipe
  import one_hot_encoder_pkg::*;
#(
  parameter  int INPUT_SIZE = INPUT_SIZE_DEF,
  parameter  int CHUNK_SIZE = CHUNK_SIZE_DEF,
  parameter  int ERR_CNT_BW = 16,
  localparam int OUTPUT_BW  = clog2_f(INPUT_SIZE)
) (
  input  logic                  clock_i,
  input  logic                  resetn_i,
  input  logic                  valid_i,
  input  logic [INPUT_SIZE-1:0] onehot_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUTPUT_BW-1:0]  index_o,
  output logic                  zero_hot_o,
  output logic                  multi_hot_o,
  output logic [ERR_CNT_BW-1:0] err_count_o,
  input  logic                  err_clear_i
);

  localparam int N_CHUNKS = INPUT_SIZE / CHUNK_SIZE;

  chunk_rec_t enc    [N_CHUNKS];
  chunk_rec_t s1_rec [N_CHUNKS];
  logic       s1_valid;
  logic       s1_advance;
  logic       s2_load;
  logic       in_xfer;
  logic       out_xfer;

  logic [OUTPUT_BW-1:0] idx_c;
  logic                 zero_c;
  logic                 multi_c;

  for (genvar c = 0; c < N_CHUNKS; c++) begin : g_chunk
    one_hot_chunk_encoder #(.CHUNK_SIZE(CHUNK_SIZE)) u_enc (
      .bits (onehot_i[c*CHUNK_SIZE +: CHUNK_SIZE]),
      .rec  (enc[c])
    );
  end

  assign out_xfer   = valid_o && ready_i;
  assign s2_load    = !valid_o || out_xfer;
  assign s1_advance = s1_valid && s2_load;
  assign ready_o    = !s1_valid || s1_advance;
  assign in_xfer    = valid_i && ready_o;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      s1_valid <= 1'b0;
      for (int c = 0; c < N_CHUNKS; c++) s1_rec[c] <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_rec   <= enc;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Lowest chunk with any bit set supplies the index; any second hit is multi-hot.
  always_comb begin
    idx_c   = '0;
    zero_c  = 1'b1;
    multi_c = 1'b0;
    for (int c = 0; c < N_CHUNKS; c++) begin
      if (s1_rec[c].multi) multi_c = 1'b1;
      if (s1_rec[c].any) begin
        if (!zero_c) begin
          multi_c = 1'b1;
        end else begin
          idx_c  = OUTPUT_BW'(c * CHUNK_SIZE) + OUTPUT_BW'(s1_rec[c].idx);
          zero_c = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      valid_o     <= 1'b0;
      index_o     <= '0;
      zero_hot_o  <= 1'b0;
      multi_hot_o <= 1'b0;
    end else if (s2_load) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        index_o     <= idx_c;
        zero_hot_o  <= zero_c;
        multi_hot_o <= multi_c;
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      err_count_o <= '0;
    end else if (err_clear_i) begin
      err_count_o <= '0;
    end else if (out_xfer && (zero_hot_o || multi_hot_o) && (err_count_o != '1)) begin
      err_count_o <= err_count_o + ERR_CNT_BW'(1);
    end
  end

endmodule
